// File: rtl/quad_decoder_bank_if.sv
// CPU-side read/clear port of the quadrature decoder bank.
// The CPU drives sel/rd/clr and samples data one cycle after rd.
interface quad_decoder_bank_if #(
  parameter int CHANNELS = 4,
  parameter int OUT_W    = 8
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SEL_W-1:0] sel;
  logic             rd;
  logic             clr;
  logic [OUT_W-1:0] data;

  modport master (
    output sel,
    output rd,
    output clr,
    input  data
  );

  modport slave (
    input  sel,
    input  rd,
    input  clr,
    output data
  );
endinterface

// File: rtl/quad_decoder_bank.sv
// Multi-channel quadrature decoder: sync, debounce, decode, count.
// CPU reads/clears one channel at a time through the bus port.
module quad_decoder_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 9,
  parameter int OUT_W    = 8,
  parameter int FILT     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] a_in,
  input  logic [CHANNELS-1:0] b_in,
  input  logic [CHANNELS-1:0] invert,
  output logic [CHANNELS-1:0] err,
  quad_decoder_bank_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int N     = 2 * CHANNELS;
  localparam logic [3:0] FSAT = 4'(FILT - 1);
  localparam logic [3:0] FPRE = 4'(FILT - 2);

  // Bit i is phase A of channel i, bit CHANNELS+i is phase B.
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] cand_q, cand_d;
  logic [N-1:0] filt_q, filt_d;
  logic [N-1:0] sat;
  logic [3:0]   fcnt_q [N];
  logic [3:0]   fcnt_d [N];

  logic [CHANNELS-1:0] primed_q, primed_d;
  logic [CHANNELS-1:0] err_q, err_d;
  logic [1:0]          ph_q [CHANNELS];
  logic [1:0]          ph_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [OUT_W-1:0]    data_q, data_d;

  logic [SEL_W-1:0] sel;
  logic [1:0]       nw;
  logic             hit, bad, fwd, up, dn;

  assign sel      = bus.sel;
  assign bus.data = data_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    s1_q <= {b_in, a_in};
    s2_q <= s1_q;
  end

  always_comb begin
    cand_d = cand_q;
    filt_d = filt_q;
    sat    = '0;
    for (int i = 0; i < N; i++) begin
      fcnt_d[i] = fcnt_q[i];
      sat[i]    = (fcnt_q[i] == FSAT);
      if (s2_q[i] != cand_q[i]) begin
        cand_d[i] = s2_q[i];
        fcnt_d[i] = '0;
        if (FILT == 1) filt_d[i] = s2_q[i];
      end else begin
        if (!sat[i]) fcnt_d[i] = fcnt_q[i] + 4'd1;
        if (fcnt_q[i] == FPRE) filt_d[i] = cand_q[i];
      end
    end
  end

  always_comb begin
    primed_d = primed_q;
    err_d    = err_q;
    data_d   = data_q;
    nw       = '0;
    hit      = 1'b0;
    bad      = 1'b0;
    fwd      = 1'b0;
    up       = 1'b0;
    dn       = 1'b0;
    if (bus.rd) data_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ph_d[c]  = ph_q[c];
      cnt_d[c] = cnt_q[c];
      nw  = {filt_q[c], filt_q[CHANNELS+c]};
      hit = (sel == SEL_W'(c));
      bad = &(ph_q[c] ^ nw);
      // For a single-bit Gray step, old A xor new B is 1 going forward.
      fwd = ph_q[c][1] ^ nw[0];
      up  = !bad && (fwd ^ invert[c]);
      dn  = !bad && !(fwd ^ invert[c]);
      if (bus.rd && hit) data_d = cnt_q[c][CNT_W-1 -: OUT_W];
      if (!primed_q[c]) begin
        if (sat[c] && sat[CHANNELS+c]) begin
          ph_d[c]     = nw;
          primed_d[c] = 1'b1;
        end
      end else if (nw != ph_q[c]) begin
        ph_d[c] = nw;
        unique case (1'b1)
          bad: err_d[c] = 1'b1;
          up:  cnt_d[c] = cnt_q[c] + CNT_W'(1);
          dn:  cnt_d[c] = cnt_q[c] - CNT_W'(1);
        endcase
      end
      if (bus.clr && hit) begin
        cnt_d[c] = '0;
        err_d[c] = 1'b0;
      end
    end
  end

  // Reset preloads the candidate from the synchroniser so priming sees pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_q   <= s2_q;
      filt_q   <= s2_q;
      primed_q <= '0;
      err_q    <= '0;
      data_q   <= '0;
      for (int i = 0; i < N; i++) fcnt_q[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ph_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      cand_q   <= cand_d;
      filt_q   <= filt_d;
      primed_q <= primed_d;
      err_q    <= err_d;
      data_q   <= data_d;
      for (int i = 0; i < N; i++) fcnt_q[i] <= fcnt_d[i];
      for (int c = 0; c < CHANNELS; c++) begin
        ph_q[c]  <= ph_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder_bank.sv
// Bench for quad_decoder_bank: directed cases plus random steps
// checked against a phase-index/count model of the channels.
module tb_quad_decoder_bank;
  localparam int CH   = 4;
  localparam int CW   = 9;
  localparam int OW   = 8;
  localparam int FL   = 3;
  localparam int HOLD = 10;
  localparam int MOD  = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] a_in, b_in, invert, err;

  quad_decoder_bank_if #(.CHANNELS(CH), .OUT_W(OW)) bus();

  quad_decoder_bank #(
    .CHANNELS(CH), .CNT_W(CW), .OUT_W(OW), .FILT(FL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_in(a_in), .b_in(b_in), .invert(invert),
    .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pos [CH];
  int cnt [CH];
  logic [CH-1:0] em;
  logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move channel ch to Gray index idx and account for it in the model.
  task automatic mstep(input int ch, input int idx);
    int d, s;
    d = (idx - pos[ch] + 4) % 4;
    if (d == 2) em[ch] = 1'b1;
    else if (d != 0) begin
      s = (d == 1) ? 1 : -1;
      if (invert[ch]) s = -s;
      cnt[ch] = (cnt[ch] + s + MOD) % MOD;
    end
    {a_in[ch], b_in[ch]} = GRAY[idx];
    pos[ch] = idx;
  endtask

  task automatic step(input int ch, input int idx);
    mstep(ch, idx);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic read_chk(input int ch);
    bus.sel = ch[1:0];
    bus.rd  = 1'b1;
    @(negedge clk);
    bus.rd  = 1'b0;
    check($sformatf("rd_ch%0d", ch), 32'(bus.data),
          32'(cnt[ch] >> (CW - OW)));
  endtask

  task automatic clear(input int ch);
    bus.sel = ch[1:0];
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    cnt[ch] = 0;
    em[ch]  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    em = '0;
    reset_n = 1'b1;
    repeat (FL + 8) @(negedge clk);
  endtask

  initial begin
    a_in = '1;
    b_in = '1;
    invert = '0;
    bus.sel = '0;
    bus.rd = 1'b0;
    bus.clr = 1'b0;
    em = '0;
    for (int c = 0; c < CH; c++) begin
      pos[c] = 2;
      cnt[c] = 0;
    end

    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.data), 0);
    check("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    repeat (FL + 8) @(negedge clk);
    read_chk(0);
    check("prime_data", 32'(bus.data), 0);
    check("prime_err", 32'(err), 0);

    step(1, 3);
    step(1, 0);
    clear(1);
    for (int k = 1; k <= 8; k++) step(1, k % 4);
    read_chk(1);
    check("fwd8", 32'(bus.data), 32'h04);
    clear(1);
    invert[1] = 1'b1;
    for (int k = 1; k <= 8; k++) step(1, k % 4);
    read_chk(1);
    check("fwd8_inv", 32'(bus.data), 32'hFC);
    invert[1] = 1'b0;

    a_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    a_in[2] = 1'b1;
    repeat (HOLD) @(negedge clk);
    read_chk(2);
    check("glitch2_err", 32'(err), 32'(em));
    a_in[2] = 1'b0;
    repeat (FL) @(negedge clk);
    a_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    bus.sel = 2'd2;
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check("glitchF_mid", 32'(bus.data), 32'hFF);
    repeat (HOLD) @(negedge clk);
    read_chk(2);
    check("glitchF_err", 32'(err), 32'(em));

    step(0, 1);
    read_chk(0);
    check("wrap_down", 32'(bus.data), 32'hFF);
    step(0, 2);
    read_chk(0);
    check("wrap_up", 32'(bus.data), 32'h00);

    step(3, 0);
    check("illegal_err", 32'(err), 32'(em));
    check("illegal_err3", 32'(err[3]), 1);
    read_chk(3);
    clear(3);
    check("clr_err", 32'(err), 32'(em));
    read_chk(3);

    clear(0);
    for (int k = 3; k <= 8; k++) step(0, k % 4);
    read_chk(0);
    mstep(0, 1);
    repeat (5) @(negedge clk);
    bus.sel = 2'd0;
    bus.rd = 1'b1;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    bus.clr = 1'b0;
    check("rdclr_data", 32'(bus.data), 32'h03);
    cnt[0] = 0;
    repeat (HOLD) @(negedge clk);
    read_chk(0);

    for (int it = 0; it < 40; it++) begin
      int m, r, d, ch;
      invert = invert ^ CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      m = $urandom_range(1, (1 << CH) - 1);
      for (int c = 0; c < CH; c++) begin
        if (m[c]) begin
          r = $urandom_range(0, 9);
          d = (r < 4) ? 1 : (r < 8) ? 3 : (r < 9) ? 2 : 0;
          mstep(c, (pos[c] + d) % 4);
        end
      end
      repeat (HOLD) @(negedge clk);
      ch = $urandom_range(0, CH - 1);
      read_chk(ch);
      check("rnd_err", 32'(err), 32'(em));
      if ($urandom_range(0, 3) == 0) clear($urandom_range(0, CH - 1));
    end

    invert = '0;
    clear(0);
    for (int k = 1; k <= 4; k++) step(0, (pos[0] + 1) % 4);
    step(3, (pos[3] + 2) % 4);
    read_chk(0);
    mstep(2, (pos[2] + 1) % 4);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(bus.data), 0);
    check("midrst_err", 32'(err), 0);
    do_reset();
    for (int c = 0; c < CH; c++) read_chk(c);
    check("post_rst_err", 32'(err), 32'(em));
    step(1, (pos[1] + 1) % 4);
    step(1, (pos[1] + 1) % 4);
    read_chk(1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
